// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory controller master: FSM states, request size
// codes and the legality check for a request.
// Optional feature macro: MEM_CTRL_SUBWORD_EN (byte/half accesses).
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // A request is rejected when its size is unsupported in this build or the
    // address is not aligned to the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
`ifdef MEM_CTRL_SUBWORD_EN
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
`else
        bad = (size != SZ_WORD) || (|addr_lo);
`endif
        return bad;
    endfunction

endpackage

// File: rtl/mem_ctrl_master_if.sv
// Request/response and memory-port signals of the memory controller master.
// Handshake rule for both channels: a transfer happens on the rising clk edge
// where valid and ready are both high; the sender holds valid and its payload
// steady until that edge, and ready may not depend combinationally on valid.
interface mem_ctrl_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_ctrl_lane.sv
// Byte-lane logic: merges store data into a fetched word and extracts /
// extends load data. Little-endian, lane 0 = bits 7:0.
// Sub-word handling exists only with MEM_CTRL_SUBWORD_EN; otherwise words pass through.
module mem_ctrl_lane
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [31:0] merge_wdata,
    output logic [31:0] load_rdata
);
`ifdef MEM_CTRL_SUBWORD_EN
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and half-word out of the fetched word.
    always_comb begin
        sel_byte = rdata_word[7:0];
        case (addr_lo)
            2'd0:    sel_byte = rdata_word[7:0];
            2'd1:    sel_byte = rdata_word[15:8];
            2'd2:    sel_byte = rdata_word[23:16];
            default: sel_byte = rdata_word[31:24];
        endcase
        sel_half = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    end

    // Right-justify the selected lane and sign- or zero-fill the upper bits.
    always_comb begin
        load_rdata = rdata_word;
        case (size)
            SZ_BYTE: load_rdata = {{24{is_signed & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_rdata = {{16{is_signed & sel_half[15]}}, sel_half};
            default: load_rdata = rdata_word;
        endcase
    end

    // Replace only the addressed lanes of the fetched word with store data.
    always_comb begin
        merge_wdata = rdata_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merge_wdata[7:0]   = wdata[7:0];
                    2'd1:    merge_wdata[15:8]  = wdata[7:0];
                    2'd2:    merge_wdata[23:16] = wdata[7:0];
                    default: merge_wdata[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) merge_wdata[31:16] = wdata[15:0];
                else            merge_wdata[15:0]  = wdata[15:0];
            end
            default: merge_wdata = wdata;
        endcase
    end
`else
    logic unused_lane;

    // Word-only build: data passes straight through in both directions.
    always_comb begin
        merge_wdata = wdata;
        load_rdata  = rdata_word;
        unused_lane = ^{size, addr_lo, is_signed};
    end
`endif
endmodule

// File: rtl/mem_ctrl_master.sv
// Memory controller master: turns core load/store requests into accesses on a
// single-port word memory. Sub-word stores use read-modify-write, misaligned or
// unsupported requests answer with rsp_err and never reach the memory.
// Optional feature macro: MEM_CTRL_SUBWORD_EN (byte/half accesses).
module mem_ctrl_master
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_ctrl_master_if.master bus,
    output state_t            state_dbg
);
    state_t                state_q, state_d;
    logic                  op_we_q, op_we_d;
    logic [1:0]            op_size_q, op_size_d;
    logic                  op_signed_q, op_signed_d;
    logic [1:0]            op_lo_q, op_lo_d;
    logic [DATA_WIDTH-1:0] op_wdata_q, op_wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] lane_wdata, lane_rdata;

    mem_ctrl_lane u_lane (
        .size        (op_size_q),
        .addr_lo     (op_lo_q),
        .is_signed   (op_signed_q),
        .wdata       (op_wdata_q),
        .rdata_word  (bus.mem_rdata),
        .merge_wdata (lane_wdata),
        .load_rdata  (lane_rdata)
    );

`ifndef MEM_CTRL_SUBWORD_EN
    logic unused_subword;
    assign unused_subword = ^{op_we_q, lane_wdata};
`endif

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        op_size_d   = op_size_q;
        op_signed_d = op_signed_q;
        op_lo_d     = op_lo_q;
        op_wdata_d  = op_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_we_d     = bus.req_we;
                    op_size_d   = bus.req_size;
                    op_signed_d = bus.req_signed;
                    op_lo_d     = bus.req_addr[1:0];
                    op_wdata_d  = bus.req_wdata;
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        mem_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (bus.req_we && bus.req_size == SZ_WORD) begin
                            state_d     = WR;
                            mem_wdata_d = bus.req_wdata;
                            mem_we_d    = 1'b1;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                // The memory read is combinational, so mem_rdata is valid here.
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = lane_rdata;
`ifdef MEM_CTRL_SUBWORD_EN
                if (op_we_q) begin
                    state_d     = WR;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    mem_wdata_d = lane_wdata;
                    mem_we_d    = 1'b1;
                end
`endif
            end
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // Latched request fields and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we_q     <= 1'b0;
            op_size_q   <= SZ_WORD;
            op_signed_q <= 1'b0;
            op_lo_q     <= 2'b00;
            op_wdata_q  <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            op_we_q     <= op_we_d;
            op_size_q   <= op_size_d;
            op_signed_q <= op_signed_d;
            op_lo_q     <= op_lo_d;
            op_wdata_q  <= op_wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_mem_ctrl_master.sv
// Bench for mem_ctrl_master: table of directed vectors, hand-written reset /
// abort sequence, seven word round-trips and randomized traffic against a
// byte-level reference model. Honours MEM_CTRL_SUBWORD_EN like the design.
module tb_mem_ctrl_master;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  logic   mem_init;
  int     checks;
  int     errors;

  logic [32:0] exp_q[$];
  vec_t        tbl[$];
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int          we_pulses;
  int          we_run;
  logic [31:0] last_we_addr;
  logic [31:0] last_we_data;
  state_t      prev_state;
  logic [31:0] prev_addr;

  mem_ctrl_master_if bus ();

  mem_ctrl_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- memory model (256 bytes, upper address bits alias) ----------------
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0000_0001;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  always_comb bus.mem_rdata = mem[bus.mem_addr[7:2]];

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory-port monitor: write pulses only in WR, one cycle wide, address held RD->WR.
  always @(negedge clk) begin
    if (!rst_n) begin
      we_run     <= 0;
      prev_state <= IDLE;
    end else begin
      if (bus.mem_we) begin
        we_run       <= we_run + 1;
        if (we_run == 0) we_pulses <= we_pulses + 1;
        last_we_addr <= bus.mem_addr;
        last_we_data <= bus.mem_wdata;
        check("mem_we_in_wr", (state_dbg == WR) ? 1 : 0, 1);
        check("mem_we_width", we_run, 0);
      end else begin
        we_run <= 0;
      end
      if (state_dbg == WR && prev_state == RD) check("mem_addr_held", bus.mem_addr, prev_addr);
      prev_state <= state_dbg;
      prev_addr  <= bus.mem_addr;
    end
  end

  // ---------------- reference model ----------------
  // Works on the byte view of memory: legality from size/alignment, stores
  // overwrite nbytes bytes, loads gather nbytes bytes and extend.
  function automatic void model_access(input logic we, input logic [1:0] size, input logic sgn,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic err, output logic [31:0] rdata, output int lat);
    int nbytes;
    int off;
    logic [31:0] word;
    logic [31:0] val;
    off    = int'(addr[1:0]);
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err    = 1'b1;
    if (size == 2'd2 && off == 0) err = 1'b0;
`ifdef MEM_CTRL_SUBWORD_EN
    if (size == 2'd0) err = 1'b0;
    if (size == 2'd1 && (off % 2) == 0) err = 1'b0;
`endif
    rdata = 32'h0;
    lat   = 1;
    if (err) return;
    word = ref_mem[addr[7:2]];
    if (we) begin
      for (int i = 0; i < nbytes; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[addr[7:2]] = word;
      lat = (nbytes == 4) ? 2 : 3;
    end else begin
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
      if (sgn && nbytes < 4 && val[8*nbytes-1])
        for (int i = nbytes; i < 4; i++) val[8*i +: 8] = 8'hFF;
      rdata = val;
      lat   = 2;
    end
  endfunction

  // ---------------- driver ----------------
  // Called and returns at a negedge with the controller idle.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                         input string tag);
    int n;
    int lat;
    int pulses0;
    logic saw_rd;
    logic [31:0] held_rdata;
    logic held_err;
    logic [32:0] exp;
    exp_q.push_back({exp_err, exp_rdata});
    pulses0        = we_pulses;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = $urandom_range(0, 1) == 1;
    bus.req_size   = 2'($urandom_range(0, 3));
    bus.req_signed = $urandom_range(0, 1) == 1;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    @(negedge clk);
    lat    = 1;
    saw_rd = 1'b0;
    while (!bus.rsp_valid && lat < 10) begin
      if (state_dbg == RD) saw_rd = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    if (exp_err) check({tag, " no_rd"}, saw_rd, 0);
    held_rdata = bus.rsp_rdata;
    held_err   = bus.rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " stall_hold"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready},
            {1'b1, held_err, held_rdata, 1'b0});
    end
    exp = exp_q.pop_front();
    check({tag, " rsp"}, {bus.rsp_err, bus.rsp_rdata}, exp);
    check({tag, " no_bypass"}, bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, " after_hs"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
    check({tag, " writes"}, we_pulses - pulses0, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err) begin
      check({tag, " wr_addr"}, last_we_addr, {addr[31:2], 2'b00});
      check({tag, " wr_data"}, last_we_data, ref_mem[addr[7:2]]);
    end
  endtask

  function automatic void add_vec(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                                  input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.stall = stall;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    tbl.push_back(v);
  endfunction

  // ---------------- test ----------------
  initial begin
    logic        m_err;
    logic [31:0] m_rdata;
    int          m_lat;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sgn;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    checks = 0;
    errors = 0;
    we_pulses = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0000_0001;

    // Directed vectors, memory starts as 0x0000_0001 in every word.
`ifdef MEM_CTRL_SUBWORD_EN
    add_vec(1, 2, 0, 32'h0,        32'd10,        0, 0, 32'h0,         2);
    add_vec(0, 2, 0, 32'h0,        32'h0,         0, 0, 32'd10,        2);
    add_vec(1, 0, 0, 32'h5,        32'hAB,        1, 0, 32'h0,         3);
    add_vec(0, 0, 1, 32'h5,        32'h0,         0, 0, 32'hFFFF_FFAB, 2);
    add_vec(0, 0, 0, 32'h5,        32'h0,         5, 0, 32'h0000_00AB, 2);
    add_vec(0, 1, 0, 32'h3,        32'h0,         0, 1, 32'h0,         1);
    add_vec(1, 1, 0, 32'hA,        32'h8001,      0, 0, 32'h0,         3);
    add_vec(0, 1, 1, 32'hA,        32'h0,         0, 0, 32'hFFFF_8001, 2);
    add_vec(0, 1, 0, 32'h8,        32'h0,         2, 0, 32'h0000_0001, 2);
    add_vec(0, 2, 0, 32'h8,        32'h0,         0, 0, 32'h8001_0001, 2);
    add_vec(0, 3, 0, 32'h0,        32'h0,         0, 1, 32'h0,         1);
    add_vec(1, 2, 0, 32'h2,        32'h1234,      0, 1, 32'h0,         1);
    add_vec(1, 0, 0, 32'h7,        32'h1234_56C3, 0, 0, 32'h0,         3);
    add_vec(0, 2, 0, 32'h4,        32'h0,         0, 0, 32'hC300_AB01, 2);
    add_vec(0, 1, 1, 32'h6,        32'h0,         0, 0, 32'hFFFF_C300, 2);
    add_vec(1, 2, 0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 0, 32'h0,        2);
    add_vec(0, 2, 0, 32'hFFFF_FFFC, 32'h0,        0, 0, 32'hDEAD_BEEF, 2);
`else
    add_vec(1, 2, 0, 32'h0,        32'd10,        0, 0, 32'h0,         2);
    add_vec(0, 2, 0, 32'h0,        32'h0,         0, 0, 32'd10,        2);
    add_vec(0, 0, 0, 32'h4,        32'h0,         0, 1, 32'h0,         1);
    add_vec(1, 0, 0, 32'h5,        32'hAB,        1, 1, 32'h0,         1);
    add_vec(0, 1, 1, 32'h8,        32'h0,         0, 1, 32'h0,         1);
    add_vec(1, 1, 0, 32'h8,        32'h8001,      0, 1, 32'h0,         1);
    add_vec(0, 2, 0, 32'h4,        32'h0,         5, 0, 32'h0000_0001, 2);
    add_vec(0, 3, 0, 32'h0,        32'h0,         0, 1, 32'h0,         1);
    add_vec(1, 2, 0, 32'h2,        32'h1234,      0, 1, 32'h0,         1);
    add_vec(1, 2, 0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 0, 32'h0,        2);
    add_vec(0, 2, 0, 32'hFFFF_FFFC, 32'h0,        0, 0, 32'hDEAD_BEEF, 2);
    add_vec(0, 2, 0, 32'h8,        32'h0,         2, 0, 32'h0000_0001, 2);
`endif

    rst_n          = 1'b0;
    mem_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(negedge clk);
    check("reset rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
    check("reset mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 65'h0);
    check("reset state", state_dbg, IDLE);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post_reset req_ready", bus.req_ready, 1);

    // Reset during the WR cycle of a word store to 0x8 must cancel the write.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h8;
    bus.req_wdata = 32'h5555_5555;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort in_wr", {state_dbg == WR, bus.mem_we}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("abort we_drop", bus.mem_we, 0);
    check("abort state", {state_dbg, bus.req_ready, bus.rsp_valid}, {IDLE, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_access(0, 2, 0, 32'h8, 32'h0, m_err, m_rdata, m_lat);
    run_req(0, 2, 0, 32'h8, 32'h0, 0, 0, 32'h0000_0001, 2, "abort load");

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      model_access(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, m_err, m_rdata, m_lat);
      run_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, tbl[i].stall,
              tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Seven word round-trips through 0x4.
    for (int i = 0; i < 7; i++) begin
      r_wdata = $urandom;
      model_access(1, 2, 0, 32'h4, r_wdata, m_err, m_rdata, m_lat);
      run_req(1, 2, 0, 32'h4, r_wdata, 0, m_err, m_rdata, m_lat, $sformatf("rt%0d st", i));
      model_access(0, 2, 0, 32'h4, 32'h0, m_err, m_rdata, m_lat);
      run_req(0, 2, 0, 32'h4, 32'h0, 0, m_err, m_rdata, m_lat, $sformatf("rt%0d ld", i));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      r_we    = $urandom_range(0, 1) == 1;
      r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_sgn   = $urandom_range(0, 1) == 1;
      r_addr  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (r_size == 2'd1) r_addr[0] = 1'b0;
        if (r_size == 2'd2) r_addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) r_addr[31:8] = 24'hFF_FFFF;
      r_wdata = $urandom;
      model_access(r_we, r_size, r_sgn, r_addr, r_wdata, m_err, m_rdata, m_lat);
      run_req(r_we, r_size, r_sgn, r_addr, r_wdata, $urandom_range(0, 2),
              m_err, m_rdata, m_lat, $sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
